// File: rtl/ttrng_stream.sv
// Parametrised random-number source: Galois LFSR / counter generator with
// runtime reseed, zero-lock recovery and a depth-1 valid/ready output buffer.
module ttrng_stream #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int unsigned      DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [1:0]       selector,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             ready,
  output logic [WIDTH-1:0] number,
  output logic             valid,
  output logic             overrun
);

  localparam logic [7:0]       DIV_LAST = 8'(DIV - 1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_r, state_nxt_s;
  logic [7:0]       step_cnt_r, step_cnt_nxt_s;
  logic [1:0]       sel_q_r;
  logic             emit_s;
  logic [WIDTH-1:0] number_nxt_s;
  logic             valid_nxt_s, overrun_nxt_s;

  // An all-zero state would lock the LFSR, so it reseeds instead of stepping.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    if (s == ZERO_W) begin
      return SEED;
    end else begin
      return (s >> 1) ^ (s[0] ? TAPS : ZERO_W);
    end
  endfunction

  // Generator next state, divider count and emit strobe.
  always_comb begin
    state_nxt_s    = state_r;
    step_cnt_nxt_s = step_cnt_r;
    emit_s         = 1'b0;
    if (seed_load) begin
      state_nxt_s    = (seed_in == ZERO_W) ? SEED : seed_in;
      step_cnt_nxt_s = 8'd0;
    end else if (selector != sel_q_r) begin
      step_cnt_nxt_s = 8'd0;
    end else if (ena && (selector != 2'b00)) begin
      case (selector)
        2'b10:   state_nxt_s = state_r + ONE_W;
        default: state_nxt_s = lfsr_step(state_r);
      endcase
      if ((selector == 2'b11) || (step_cnt_r == DIV_LAST)) begin
        emit_s         = 1'b1;
        step_cnt_nxt_s = 8'd0;
      end else begin
        step_cnt_nxt_s = step_cnt_r + 8'd1;
      end
    end else begin
      state_nxt_s    = state_r;
      step_cnt_nxt_s = step_cnt_r;
    end
  end

  // Depth-1 output buffer: new words replace a consumed or empty slot, else overrun.
  always_comb begin
    number_nxt_s  = number;
    valid_nxt_s   = valid;
    overrun_nxt_s = overrun;
    if (seed_load) begin
      valid_nxt_s = 1'b0;
    end else if (emit_s) begin
      if (!valid || ready) begin
        number_nxt_s = state_nxt_s;
        valid_nxt_s  = 1'b1;
      end else begin
        overrun_nxt_s = 1'b1;
      end
    end else if (valid && ready) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid;
    end
  end

  // Generator state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= SEED;
      step_cnt_r <= 8'd0;
      sel_q_r    <= 2'b00;
    end else begin
      state_r    <= state_nxt_s;
      step_cnt_r <= step_cnt_nxt_s;
      sel_q_r    <= selector;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      number  <= ZERO_W;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      number  <= number_nxt_s;
      valid   <= valid_nxt_s;
      overrun <= overrun_nxt_s;
    end
  end

endmodule

// File: tb/tb_ttrng_stream.sv
// Self-checking bench for ttrng_stream: directed scenarios plus randomized
// traffic compared each cycle against a behavioural word-stream model.
module tb_ttrng_stream;

  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'h01;
  localparam int         DIV  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [1:0] selector = 2'b00;
  logic       seed_load = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic       ready = 1'b0;
  logic [7:0] number;
  logic       valid;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  // Model: generator value, steps taken since last word, previous selector, buffer.
  logic [7:0] m_gen;
  int         m_steps;
  logic [1:0] m_prev_sel;
  logic [7:0] m_num;
  logic       m_valid;
  logic       m_ovr;

  ttrng_stream #(.WIDTH(8), .TAPS(TAPS), .SEED(SEED), .DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .selector(selector),
    .seed_load(seed_load), .seed_in(seed_in), .ready(ready),
    .number(number), .valid(valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] next_val(input logic [1:0] mode, input logic [7:0] v);
    if (mode == 2'b10) return v + 8'd1;
    if (v == 8'h00) return SEED;
    return {1'b0, v[7:1]} ^ (v[0] ? TAPS : 8'h00);
  endfunction

  function automatic void model_reset();
    m_gen = SEED; m_steps = 0; m_prev_sel = 2'b00;
    m_num = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
  endfunction

  // Apply one cycle of inputs, advance the model, then compare outputs after the edge.
  task automatic cycle(input logic [1:0] sel, input logic en, input logic ld,
                       input logic [7:0] sin, input logic rdy);
    bit word_out;
    selector = sel; ena = en; seed_load = ld; seed_in = sin; ready = rdy;
    word_out = 1'b0;
    if (ld) begin
      m_gen = (sin == 8'h00) ? SEED : sin;
      m_steps = 0;
      m_valid = 1'b0;
    end else begin
      if (sel != m_prev_sel) begin
        m_steps = 0;
      end else if (en && sel != 2'b00) begin
        m_gen = next_val(sel, m_gen);
        m_steps = m_steps + 1;
        if (sel == 2'b11 || m_steps == DIV) begin
          word_out = 1'b1;
          m_steps = 0;
        end
      end
      if (word_out) begin
        if (!m_valid || rdy) begin
          m_num = m_gen; m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    m_prev_sel = sel;
    @(posedge clk);
    #1;
    check_eq("valid", {31'd0, valid}, {31'd0, m_valid});
    check_eq("number", {24'd0, number}, {24'd0, m_num});
    check_eq("overrun", {31'd0, overrun}, {31'd0, m_ovr});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    selector = 2'b00; ena = 1'b0; seed_load = 1'b0; seed_in = 8'h00; ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int first_hit;
    do_reset();
    check_eq("reset_number", {24'd0, number}, 32'd0);
    check_eq("reset_valid", {31'd0, valid}, 32'd0);
    check_eq("reset_overrun", {31'd0, overrun}, 32'd0);

    // Mode 01 from reset: mode-change cycle then four steps to the first word.
    for (int i = 0; i < 5; i++) cycle(2'b01, 1'b1, 1'b0, 8'h00, 1'b1);
    check_eq("tp_lfsr_first", {24'd0, number}, 32'h17);
    check_eq("tp_lfsr_valid", {31'd0, valid}, 32'd1);
    for (int i = 0; i < 4; i++) cycle(2'b01, 1'b1, 1'b0, 8'h00, 1'b1);

    // Counter mode with ready low, then overrun, then drain.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(2'b10, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("tp_cnt_first", {24'd0, number}, 32'h05);
    for (int i = 0; i < 4; i++) cycle(2'b10, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("tp_cnt_ovr", {31'd0, overrun}, 32'd1);
    check_eq("tp_cnt_held", {24'd0, number}, 32'h05);
    for (int i = 0; i < 4; i++) cycle(2'b10, 1'b1, 1'b0, 8'h00, 1'b1);
    check_eq("tp_cnt_next", {24'd0, number}, 32'h0D);

    // Zero seed recovers to SEED; seed 0x80 in fast mode.
    cycle(2'b11, 1'b1, 1'b1, 8'h00, 1'b1);
    check_eq("tp_seed0_valid", {31'd0, valid}, 32'd0);
    cycle(2'b11, 1'b1, 1'b0, 8'h00, 1'b1);
    check_eq("tp_seed0_word", {24'd0, number}, 32'hB8);
    cycle(2'b11, 1'b1, 1'b1, 8'h80, 1'b1);
    cycle(2'b11, 1'b1, 1'b0, 8'h00, 1'b1);
    check_eq("tp_seed80_word", {24'd0, number}, 32'h40);

    // ena low freezes, then resumes.
    for (int i = 0; i < 10; i++) cycle(2'b11, 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(2'b11, 1'b1, 1'b0, 8'h00, 1'b1);

    // Full period of the fast LFSR from 0x01.
    cycle(2'b11, 1'b1, 1'b1, 8'h01, 1'b1);
    first_hit = 0;
    for (int i = 1; i <= 255; i++) begin
      cycle(2'b11, 1'b1, 1'b0, 8'h00, 1'b1);
      if (first_hit == 0 && valid && number == 8'h01) first_hit = i;
    end
    check_eq("period_first_return", first_hit, 255);

    // Mode switch mid-count: 01 for 2 steps, then 10.
    for (int i = 0; i < 3; i++) cycle(2'b01, 1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) cycle(2'b10, 1'b1, 1'b0, 8'h00, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] s;
      s = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : selector;
      cycle(s, ($urandom_range(0, 9) != 0), ($urandom_range(0, 63) == 0),
            8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 255)),
            ($urandom_range(0, 2) != 0));
    end

    // Force an overrun, then reset asynchronously between clock edges.
    for (int i = 0; i < 3; i++) cycle(2'b11, 1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("pre_rst_ovr", {31'd0, overrun}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_number", {24'd0, number}, 32'd0);
    check_eq("async_valid", {31'd0, valid}, 32'd0);
    check_eq("async_overrun", {31'd0, overrun}, 32'd0);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(2'b11, 1'b1, 1'b0, 8'h00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
